pipe_stage_skid: RTL and testbench

// - Generic inter-stage pipeline register with a valid/ready handshake; replaces the hand-written per-stage latch banks (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
// - Payload is one packed bus: control bits in the LSBs, data bits above them.
// - Adds backpressure through an optional 2-entry skid buffer, a flush that kills in-flight entries, and zeroed control bits whenever empty, so an empty stage is a NOP.
// - Carries saturating stall/bubble counters for CPI analysis.

---
 rtl/pipe_stage_skid.sv | 169 ++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid buffer,
// flush, NOP-on-empty payload and saturating stall/bubble counters.
module pipe_stage_skid #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam bit               HAS_SKID = (SKID != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // The zeroed control field must fit inside the payload.
  if (CTRL_W < 1 || CTRL_W > DATA_W) begin : g_bad_ctrl_w
    $error("pipe_stage_skid: CTRL_W must be in 1..DATA_W");
  end

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [DATA_W-1:0] main_r, main_nxt_s, skid_s;
  logic              in_ready_s, out_valid_s, in_fire_s, out_fire_s;
  logic [CNT_W-1:0]  stall_r, bubble_r;

  assign in_fire_s  = in_valid & in_ready_s;
  assign out_fire_s = out_valid_s & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and next main payload; every path into EMPTY zeroes main
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
      main_nxt_s  = '0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_nxt_s = ST_ONE;
            main_nxt_s  = in_data;
          end else begin
            state_nxt_s = ST_EMPTY;
            main_nxt_s  = main_r;
          end
        end
        ST_ONE: begin
          if (in_fire_s && (out_fire_s || !HAS_SKID)) begin
            state_nxt_s = ST_ONE;
            main_nxt_s  = in_data;
          end else if (in_fire_s) begin
            state_nxt_s = ST_FULL;
            main_nxt_s  = main_r;
          end else if (out_fire_s) begin
            state_nxt_s = ST_EMPTY;
            main_nxt_s  = '0;
          end else begin
            state_nxt_s = ST_ONE;
            main_nxt_s  = main_r;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            state_nxt_s = ST_ONE;
            main_nxt_s  = skid_s;
          end else begin
            state_nxt_s = ST_FULL;
            main_nxt_s  = main_r;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
          main_nxt_s  = '0;
        end
      endcase
    end
  end

  // Handshake outputs; with the skid buffer in_ready never looks at out_ready
  always_comb begin
    out_valid_s = (state_r != ST_EMPTY);
    if (rst) begin
      in_ready_s = 1'b0;
    end else if (HAS_SKID) begin
      in_ready_s = (state_r != ST_FULL);
    end else begin
      in_ready_s = !out_valid_s || out_ready;
    end
  end

  // Main payload register
  always_ff @(posedge clk) begin
    if (rst) begin
      main_r <= '0;
    end else begin
      main_r <= main_nxt_s;
    end
  end

  if (HAS_SKID) begin : g_skid
    logic [DATA_W-1:0] skid_r;
    logic              skid_ld_s;

    assign skid_ld_s = (state_r == ST_ONE) && in_fire_s && !out_fire_s;

    // Skid register catches the beat that arrives while main is stalled
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        skid_r <= '0;
      end else if (skid_ld_s) begin
        skid_r <= in_data;
      end else begin
        skid_r <= skid_r;
      end
    end

    assign skid_s = skid_r;
  end else begin : g_no_skid
    assign skid_s = '0;
  end

  // Saturating performance counters, judged on pre-edge handshake state
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_r  <= '0;
      bubble_r <= '0;
    end else begin
      if (out_valid_s && !out_ready && (stall_r != CNT_MAX)) begin
        stall_r <= stall_r + CNT_ONE;
      end
      if (!out_valid_s && (bubble_r != CNT_MAX)) begin
        bubble_r <= bubble_r + CNT_ONE;
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_s;
  assign out_data   = main_r;
  assign stall_cnt  = stall_r;
  assign bubble_cnt = bubble_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a skid instance (CNT_W=4) and a no-skid instance share stimulus;
// queue-based reference models are compared every cycle, plus directed literal checks.
module tb_pipe_stage_skid;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, in_valid, out_ready, flush, cnt_clr;
  logic [DW-1:0] in_data;

  logic          a_in_ready, a_out_valid;
  logic [DW-1:0] a_out_data;
  logic [3:0]    a_stall, a_bubble;
  logic          b_in_ready, b_out_valid;
  logic [DW-1:0] b_out_data;
  logic [15:0]   b_stall, b_bubble;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(8), .SKID(1), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(a_stall), .bubble_cnt(a_bubble)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(8), .SKID(0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(b_stall), .bubble_cnt(b_bubble)
  );

  // Reference model: each stage is a FIFO of held payloads with a capacity rule
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  int unsigned   sa = 0, ba = 0, sb = 0, bb = 0;
  bit            ma_in, ma_out, mb_in, mb_out;

  always @(posedge clk) begin
    ma_in  = in_valid && !rst && (qa.size() < 2);
    ma_out = (qa.size() != 0) && out_ready;
    mb_in  = in_valid && !rst && ((qb.size() == 0) || out_ready);
    mb_out = (qb.size() != 0) && out_ready;
    if (rst || cnt_clr) begin
      sa = 0; ba = 0; sb = 0; bb = 0;
    end else begin
      if ((qa.size() != 0) && !out_ready && (sa < 15)) sa++;
      if ((qa.size() == 0) && (ba < 15)) ba++;
      if ((qb.size() != 0) && !out_ready && (sb < 65535)) sb++;
      if ((qb.size() == 0) && (bb < 65535)) bb++;
    end
    if (rst || flush) begin
      qa.delete();
      qb.delete();
    end else begin
      if (ma_out) void'(qa.pop_front());
      if (ma_in) qa.push_back(in_data);
      if (mb_out) void'(qb.pop_front());
      if (mb_in) qb.push_back(in_data);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_out_valid", 64'(a_out_valid), 64'(qa.size() != 0));
      check("a_out_data", 64'(a_out_data), (qa.size() != 0) ? 64'(qa[0]) : 64'd0);
      check("a_in_ready", 64'(a_in_ready), 64'(!rst && (qa.size() < 2)));
      check("a_stall", 64'(a_stall), 64'(sa));
      check("a_bubble", 64'(a_bubble), 64'(ba));
      check("b_out_valid", 64'(b_out_valid), 64'(qb.size() != 0));
      check("b_out_data", 64'(b_out_data), (qb.size() != 0) ? 64'(qb[0]) : 64'd0);
      check("b_in_ready", 64'(b_in_ready), 64'(!rst && ((qb.size() == 0) || out_ready)));
      check("b_stall", 64'(b_stall), 64'(sb));
      check("b_bubble", 64'(b_bubble), 64'(bb));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    step();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_valid", 64'(a_out_valid), 64'd0);
    check("rst_data", 64'(a_out_data), 64'd0);
    check("rst_in_ready", 64'(a_in_ready), 64'd0);
    check("rst_bubble", 64'(a_bubble), 64'd0);
    step();
    rst = 1'b0; in_valid = 1'b1; in_data = 32'd1; out_ready = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 64'(a_in_ready), 64'd1);

    // Streaming 1..8 with no gaps
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k < 8) in_data = 32'(k + 1);
      else in_valid = 1'b0;
      @(negedge clk);
      check("stream_valid", 64'(a_out_valid), 64'd1);
      check("stream_data", 64'(a_out_data), 64'(k));
    end
    check("stream_bubble", 64'(a_bubble), 64'd1);
    check("stream_stall", 64'(a_stall), 64'd0);

    // Backpressure: 0xA then 0xB while stalled
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step();
    in_data = 32'hC;
    @(negedge clk);
    check("bp_full_in_ready", 64'(a_in_ready), 64'd0);
    check("bp_hold_data", 64'(a_out_data), 64'hA);
    check("bp_stall1", 64'(a_stall), 64'd1);
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_hold_data2", 64'(a_out_data), 64'hA);
    check("bp_stall2", 64'(a_stall), 64'd2);
    check("bp_in_ready_indep", 64'(a_in_ready), 64'd0);
    step();
    @(negedge clk);
    check("bp_drain_b", 64'(a_out_data), 64'hB);
    check("bp_stall_kept", 64'(a_stall), 64'd2);
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    @(negedge clk);
    check("bp_empty_valid", 64'(a_out_valid), 64'd0);
    check("bp_empty_data", 64'(a_out_data), 64'd0);

    // Flush while FULL with 0xC offered
    step();
    in_data = 32'hB;
    step();
    flush = 1'b1; in_data = 32'hC;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_valid", 64'(a_out_valid), 64'd0);
    check("flush_data", 64'(a_out_data), 64'd0);
    check("flush_in_ready", 64'(a_in_ready), 64'd1);
    step();
    cnt_clr = 1'b1;
    @(negedge clk);
    check("flush_still_empty", 64'(a_out_valid), 64'd0);

    // No-skid instance: out_ready toggles 1,0,1 under continuous input
    step();
    cnt_clr = 1'b0; in_valid = 1'b1; in_data = 32'h21; out_ready = 1'b1;
    @(negedge clk);
    check("ns_stall_clr", 64'(b_stall), 64'd0);
    step();
    in_data = 32'h22; out_ready = 1'b0;
    @(negedge clk);
    check("ns_data21", 64'(b_out_data), 64'h21);
    check("ns_in_ready_comb", 64'(b_in_ready), 64'd0);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check("ns_hold21", 64'(b_out_data), 64'h21);
    check("ns_in_ready_back", 64'(b_in_ready), 64'd1);
    step();
    in_data = 32'h23;
    @(negedge clk);
    check("ns_data22", 64'(b_out_data), 64'h22);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("ns_data23", 64'(b_out_data), 64'h23);
    step();
    cnt_clr = 1'b1;
    @(negedge clk);
    check("ns_drained", 64'(b_out_valid), 64'd0);
    check("ns_one_stall", 64'(b_stall), 64'd1);

    // Saturation and clear on the 4-bit counters
    step();
    cnt_clr = 1'b0;
    @(negedge clk);
    check("clr_beats_inc", 64'(a_bubble), 64'd0);
    for (int i = 0; i < 20; i++) step();
    @(negedge clk);
    check("bubble_sat", 64'(a_bubble), 64'd15);
    check("b_bubble_20", 64'(b_bubble), 64'd20);
    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    @(negedge clk);
    check("bubble_clr", 64'(a_bubble), 64'd0);

    // Reset while FULL
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step();
    rst = 1'b1; in_data = 32'hC;
    @(negedge clk);
    check("mr_full_data", 64'(a_out_data), 64'hA);
    check("mr_in_ready_rst", 64'(a_in_ready), 64'd0);
    step();
    @(negedge clk);
    check("mr_valid", 64'(a_out_valid), 64'd0);
    check("mr_data", 64'(a_out_data), 64'd0);
    check("mr_stall", 64'(a_stall), 64'd0);
    check("mr_bubble", 64'(a_bubble), 64'd0);
    check("mr_in_ready", 64'(a_in_ready), 64'd0);
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("mr_in_ready_rel", 64'(a_in_ready), 64'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step();
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      cnt_clr   = ($urandom_range(0, 63) == 0);
      rst       = ($urandom_range(0, 255) == 0);
    end
    step();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
